// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcodes and FSM state encoding for the SPI burst RAM slave
package spi_ram_pkg;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_WDATA,
    ST_RDUMMY,
    ST_RDATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-flop synchroniser with single-clk rise/fall strobes
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], din};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {3{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  // Third stage only remembers the previous synchronised level for edge detection.
  assign dout = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_ram_burst_slave.sv
// rtl/spi_ram_burst_slave.sv - SPI slave with burst write/read access to an internal RAM
module spi_ram_burst_slave
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DUMMY  = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic frame_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + ADDR_W + DUMMY + 4) + 1;

  logic cs_s, cs_rise, cs_fall;
  logic sclk_rise, sclk_fall, mosi_s;
  logic unused_sclk_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_edge_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(spi_cs),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .reset(reset), .din(spi_clk),
    .dout(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         opc_q, opc_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               miso_q, miso_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    opc_d     = opc_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    err_d     = 1'b0;
    busy_d    = ~cs_s;
    ram_we    = 1'b0;
    ram_wdata = {mosi_s, rx_q[DATA_W-1:1]};
    rd_data_d = ram_q[addr_q];
    if (cs_rise) begin
      // A partially received write word is dropped and flagged; a partial read is harmless.
      if (state_q == ST_OPC || state_q == ST_ADDR ||
          (state_q == ST_WDATA && cnt_q != '0)) err_d = 1'b1;
      state_d = ST_IDLE;
      cnt_d   = '0;
      tx_d    = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_d = ST_OPC;
          cnt_d   = '0;
        end
        ST_OPC: if (sclk_rise) begin
          opc_d = {mosi_s, opc_q[3:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) begin
            cnt_d = '0;
            if (opc_d == OP_WRITE || opc_d == OP_READ) state_d = ST_ADDR;
            else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        ST_ADDR: if (sclk_rise) begin
          addr_d = {mosi_s, addr_q[ADDR_W-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d = '0;
            if (opc_q == OP_WRITE) state_d = ST_WDATA;
            else if (DUMMY > 0)    state_d = ST_RDUMMY;
            else                   state_d = ST_RDATA;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          rx_d  = ram_wdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            ram_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = '0;
          end
        end
        ST_RDUMMY: if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DUMMY - 1)) begin
            cnt_d   = '0;
            state_d = ST_RDATA;
          end
        end
        ST_RDATA: if (sclk_fall) begin
          // addr advances while the last bit is presented so the next word is prefetched in time.
          if (cnt_q == '0) tx_d = rd_data_q;
          else             tx_d = tx_q >> 1;
          miso_d = tx_d[0];
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      opc_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      opc_q   <= opc_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[addr_q] <= ram_wdata;
    rd_data_q <= rd_data_d;
  end

  assign spi_miso  = miso_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb/tb_spi_ram_burst_slave.sv - randomized self-checking bench for spi_ram_burst_slave
module tb_spi_ram_burst_slave;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_mosi = 1'b0;
  logic cs0 = 1'b1;
  logic cs1 = 1'b1;
  logic miso0, busy0, ferr0;
  logic miso1, busy1, ferr1;

  int n_cmp = 0;
  int n_bad = 0;
  int errc0 = 0;
  int errc1 = 0;

  bit txb[$];
  bit rxb[$];
  int unsigned wq[$];
  logic [7:0]  ref0 [16];
  logic [15:0] ref1 [64];

  always #5 clk = ~clk;

  spi_ram_burst_slave dut0 (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs(cs0), .spi_mosi(spi_mosi),
    .spi_miso(miso0), .busy(busy0), .frame_err(ferr0)
  );

  spi_ram_burst_slave #(.DATA_W(16), .ADDR_W(6), .DUMMY(0)) dut1 (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs(cs1), .spi_mosi(spi_mosi),
    .spi_miso(miso1), .busy(busy1), .frame_err(ferr1)
  );

  // Counting high cycles makes a stretched error pulse show up as a count > 1.
  always @(negedge clk) begin
    if (ferr0) errc0++;
    if (ferr1) errc1++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic int aw_of(input int sel); return sel ? 6 : 4; endfunction
  function automatic int dw_of(input int sel); return sel ? 16 : 8; endfunction
  function automatic int dm_of(input int sel); return sel ? 0 : 7; endfunction

  function automatic int unsigned ref_get(input int sel, input int unsigned a);
    if (sel != 0) return 32'(ref1[a % 64]);
    return 32'(ref0[a % 16]);
  endfunction

  task automatic ref_set(input int sel, input int unsigned a, input int unsigned v);
    if (sel != 0) ref1[a % 64] = 16'(v);
    else          ref0[a % 16] = 8'(v);
  endtask

  task automatic push_field(input int unsigned v, input int n);
    for (int i = 0; i < n; i++) txb.push_back(v[i]);
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) txb.push_back(1'b0);
  endtask

  task automatic spi_bit(input int sel, input bit b, output bit r);
    spi_mosi = b;
    #60;
    r = (sel != 0) ? miso1 : miso0;
    spi_clk = 1'b1;
    #60;
    spi_clk = 1'b0;
  endtask

  task automatic cs_low(input int sel);
    if (sel != 0) cs1 = 1'b0; else cs0 = 1'b0;
    #100;
    n_cmp++;
    if (((sel != 0) ? busy1 : busy0) !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_in_frame sel=%0d got=%b exp=1", sel, (sel != 0) ? busy1 : busy0);
    end
  endtask

  task automatic cs_high(input int sel);
    #60;
    if (sel != 0) cs1 = 1'b1; else cs0 = 1'b1;
    #200;
    n_cmp++;
    if (((sel != 0) ? busy1 : busy0) !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_frame sel=%0d got=%b exp=0", sel, (sel != 0) ? busy1 : busy0);
    end
  endtask

  task automatic run_frame(input int sel);
    bit r;
    rxb.delete();
    cs_low(sel);
    foreach (txb[i]) begin
      spi_bit(sel, txb[i], r);
      rxb.push_back(r);
    end
    cs_high(sel);
  endtask

  task automatic do_write(input int sel, input int unsigned addr);
    int e0;
    txb.delete();
    push_field(1, 4);
    push_field(addr, aw_of(sel));
    foreach (wq[k]) push_field(wq[k], dw_of(sel));
    e0 = (sel != 0) ? errc1 : errc0;
    run_frame(sel);
    foreach (wq[k]) ref_set(sel, addr + k, wq[k]);
    n_cmp++;
    if (((sel != 0) ? errc1 : errc0) - e0 != 0) begin
      n_bad++;
      $display("FAIL write_err sel=%0d got=%0d exp=0", sel, ((sel != 0) ? errc1 : errc0) - e0);
    end
  endtask

  task automatic do_read(input int sel, input int unsigned addr, input int n);
    int e0, off;
    int unsigned w, expv;
    txb.delete();
    push_field(2, 4);
    push_field(addr, aw_of(sel));
    push_zeros(dm_of(sel) + n * dw_of(sel));
    e0 = (sel != 0) ? errc1 : errc0;
    run_frame(sel);
    off = 4 + aw_of(sel) + dm_of(sel);
    for (int k = 0; k < n; k++) begin
      w = 0;
      for (int j = 0; j < dw_of(sel); j++) if (rxb[off + k * dw_of(sel) + j]) w |= (32'd1 << j);
      expv = ref_get(sel, addr + k);
      n_cmp++;
      if (w !== expv) begin
        n_bad++;
        $display("FAIL read_word sel=%0d addr=%0h got=%0h exp=%0h", sel,
                 (addr + k) % (1 << aw_of(sel)), w, expv);
      end
    end
    n_cmp++;
    if (((sel != 0) ? errc1 : errc0) - e0 != 0) begin
      n_bad++;
      $display("FAIL read_err sel=%0d got=%0d exp=0", sel, ((sel != 0) ? errc1 : errc0) - e0);
    end
  endtask

  task automatic test_reset;
    #23;
    n_cmp++;
    if ({miso0, busy0, ferr0, miso1, busy1, ferr1} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=000000", {miso0, busy0, ferr0, miso1, busy1, ferr1});
    end
    reset = 1'b0;
    #100;
    n_cmp++;
    if ({miso0, busy0, ferr0, miso1, busy1, ferr1} !== 6'b0) begin
      n_bad++;
      $display("FAIL post_reset_outputs got=%b exp=000000", {miso0, busy0, ferr0, miso1, busy1, ferr1});
    end
  endtask

  task automatic test_init_and_basic;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back($urandom_range(0, 255));
    do_write(0, 0);
    wq.delete(); wq.push_back(32'hAA);
    do_write(0, 0);
    do_read(0, 0, 1);
  endtask

  task automatic test_burst_wrap;
    wq.delete(); wq.push_back(32'h11); wq.push_back(32'h22); wq.push_back(32'h33);
    do_write(0, 14);
    do_read(0, 15, 2);
    do_read(0, 14, 3);
  endtask

  task automatic test_random_bursts;
    for (int it = 0; it < 6; it++) begin
      wq.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) wq.push_back($urandom_range(0, 255));
      do_write(0, $urandom_range(0, 15));
      do_read(0, $urandom_range(0, 15), $urandom_range(1, 5));
    end
  endtask

  task automatic test_bad_opcode;
    int ops[4];
    int e0;
    ops = '{0, 3, 7, 15};
    for (int i = 0; i < 4; i++) begin
      txb.delete();
      push_field(ops[i], 4);
      push_field($urandom, 16);
      e0 = errc0;
      run_frame(0);
      n_cmp++;
      if (errc0 - e0 != 1) begin
        n_bad++;
        $display("FAIL bad_op_err op=%0h got=%0d exp=1", ops[i], errc0 - e0);
      end
      n_cmp++;
      if (rxb.sum() with (int'(item)) != 0) begin
        n_bad++;
        $display("FAIL bad_op_miso op=%0h got=%0d ones exp=0", ops[i], rxb.sum() with (int'(item)));
      end
    end
  endtask

  task automatic test_partial_frames;
    int e0;
    int unsigned nv;
    nv = ~ref_get(0, 3);
    txb.delete(); push_field(1, 4); push_field(3, 4); push_field(nv, 5);
    e0 = errc0;
    run_frame(0);
    n_cmp++;
    if (errc0 - e0 != 1) begin
      n_bad++;
      $display("FAIL partial_write_err got=%0d exp=1", errc0 - e0);
    end
    do_read(0, 3, 1);
    txb.delete(); push_field(1, 4); push_field(1, 2);
    e0 = errc0;
    run_frame(0);
    n_cmp++;
    if (errc0 - e0 != 1) begin
      n_bad++;
      $display("FAIL cs_in_addr_err got=%0d exp=1", errc0 - e0);
    end
    txb.delete(); push_field(2, 2);
    e0 = errc0;
    run_frame(0);
    n_cmp++;
    if (errc0 - e0 != 1) begin
      n_bad++;
      $display("FAIL cs_in_opc_err got=%0d exp=1", errc0 - e0);
    end
    txb.delete(); push_field(2, 4); push_field(6, 4); push_zeros(7 + 3);
    e0 = errc0;
    run_frame(0);
    n_cmp++;
    if (errc0 - e0 != 0 || {rxb[17], rxb[16], rxb[15]} !== 3'(ref_get(0, 6))) begin
      n_bad++;
      $display("FAIL partial_read got_err=%0d bits=%b exp_err=0 bits=%b", errc0 - e0,
               {rxb[17], rxb[16], rxb[15]}, 3'(ref_get(0, 6)));
    end
  endtask

  task automatic test_reset_mid_frame;
    bit r;
    wq.delete(); wq.push_back(32'hFF); wq.push_back(32'hFF);
    do_write(0, 5);
    txb.delete(); push_field(2, 4); push_field(5, 4); push_zeros(7 + 16);
    cs_low(0);
    for (int i = 0; i < 19; i++) spi_bit(0, txb[i], r);
    n_cmp++;
    if (r !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_read_bit got=%b exp=1", r);
    end
    #40;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({miso0, busy0} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_read got=%b exp=00", {miso0, busy0});
    end
    #20 cs0 = 1'b1;
    #30 reset = 1'b0;
    #200;
    do_read(0, 5, 2);
    txb.delete(); push_field(1, 4); push_field(9, 4); push_field(~ref_get(0, 9), 5);
    cs_low(0);
    foreach (txb[i]) spi_bit(0, txb[i], r);
    reset = 1'b1;
    #20 cs0 = 1'b1;
    #30 reset = 1'b0;
    #200;
    do_read(0, 9, 1);
  endtask

  task automatic test_wide;
    wq.delete(); wq.push_back(32'hBEEF);
    do_write(1, 63);
    do_read(1, 63, 1);
    wq.delete();
    for (int k = 0; k < 4; k++) wq.push_back($urandom_range(0, 65535));
    do_write(1, 62);
    do_read(1, 62, 4);
  endtask

  initial begin
    test_reset();
    test_init_and_basic();
    test_burst_wrap();
    test_random_bursts();
    test_bad_opcode();
    test_partial_frames();
    test_reset_mid_frame();
    test_wide();
    do_read(0, $urandom_range(0, 15), 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
